// File: rtl/display_pkg.sv
// display_pkg
// Shared types and default 640x480@60 VGA timing for the display read side
// and the frame-store controller.
//   color_t : 4-bit palette index
//   coord_t : 9-bit buffer coordinate (320x240 store)
//   vcnt_t  : 10-bit raster counter
package display_pkg;

  typedef logic [3:0] color_t;
  typedef logic [8:0] coord_t;
  typedef logic [9:0] vcnt_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_SYNC_POL = 1'b0;

  // Pin level for a sync signal given whether the raster is inside the pulse.
  function automatic logic sync_level(input logic in_pulse, input logic pol);
    return in_pulse ? pol : ~pol;
  endfunction

endpackage

// File: rtl/display_scanout_timing.sv
// video_timing
// Raster counters and decode for the scanout engine.
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   h_o, v_o        : current raster position
//   active_o        : position lies in the visible region
//   hsync_act_o     : horizontal counter inside the sync pulse
//   vsync_act_o     : vertical counter inside the sync pulse
//   blank_start_o   : position is (0, V_ACTIVE), first blanking line
//   origin_o        : position is (0, 0)
module video_timing
  import display_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic  clk,
  input  logic  rst,
  output vcnt_t h_o,
  output vcnt_t v_o,
  output logic  active_o,
  output logic  hsync_act_o,
  output logic  vsync_act_o,
  output logic  blank_start_o,
  output logic  origin_o
);

  localparam vcnt_t H_ACT  = vcnt_t'(H_ACTIVE);
  localparam vcnt_t H_SS   = vcnt_t'(H_ACTIVE + H_FP);
  localparam vcnt_t H_SE   = vcnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vcnt_t H_LAST = vcnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam vcnt_t V_ACT  = vcnt_t'(V_ACTIVE);
  localparam vcnt_t V_SS   = vcnt_t'(V_ACTIVE + V_FP);
  localparam vcnt_t V_SE   = vcnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam vcnt_t V_LAST = vcnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  vcnt_t h_q, h_d;
  vcnt_t v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_act_o   = (h_q >= H_SS) && (h_q < H_SE);
  assign vsync_act_o   = (v_q >= V_SS) && (v_q < V_SE);
  assign blank_start_o = (h_q == '0) && (v_q == V_ACT);
  assign origin_o      = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/display_scanout.sv
// display_scanout
// Read side of the double-buffered frame store. Generates VGA timing, reads a
// 320x240 buffer pixel-doubled to 640x480, and owns the buffer swap strobe.
// Ports:
//   clk, rst                  : pixel clock, synchronous active-high reset
//   flip_req                  : draw side finished a frame (pulse or level)
//   display_flip, flip_done   : one-cycle swap strobe / completion pulse
//   rd_en, rd_x, rd_y         : frame-store read request
//   rd_c, rd_vld              : read data, one cycle after rd_en
//   hsync, vsync, de, pix_c   : video out, two cycles after the request
//   frame_start               : pulse with the first de of a frame
//   underrun, underrun_clr    : sticky missing-read-data flag and its clear
module display_scanout
  import display_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flip_req,
  output logic   display_flip,
  output logic   flip_done,
  output logic   rd_en,
  output coord_t rd_x,
  output coord_t rd_y,
  input  color_t rd_c,
  input  logic   rd_vld,
  output logic   hsync,
  output logic   vsync,
  output logic   de,
  output color_t pix_c,
  output logic   frame_start,
  output logic   underrun,
  input  logic   underrun_clr
);

  vcnt_t h, v;
  logic  active, hs_act, vs_act, blank_start, origin;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .h_o          (h),
    .v_o          (v),
    .active_o     (active),
    .hsync_act_o  (hs_act),
    .vsync_act_o  (vs_act),
    .blank_start_o(blank_start),
    .origin_o     (origin)
  );

  // ---- stage p0: read request, straight from the counter registers ----
  // Gated by rst so no request is presented while the engine is held.
  assign rd_en = active & ~rst;
  assign rd_x  = rd_en ? h[9:1] : '0;
  assign rd_y  = rd_en ? v[9:1] : '0;

  logic vld_p1, hs_p1, vs_p1, fs_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      hs_p1  <= hs_act;
      vs_p1  <= vs_act;
      fs_p1  <= origin & rd_en;
    end
  end

  // ---- stage p1 -> p2: data returns, everything registered to the pins ----
  color_t pix_c_d;
  logic   underrun_q, underrun_d;
  logic   de_q, hsync_q, vsync_q, frame_start_q;
  color_t pix_c_q;

  always_comb begin
    pix_c_d    = (vld_p1 && rd_vld) ? rd_c : '0;
    // A fresh underrun outranks a clear arriving in the same cycle.
    underrun_d = (vld_p1 & ~rd_vld) | (underrun_q & ~underrun_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      pix_c_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      de_q          <= vld_p1;
      hsync_q       <= sync_level(hs_p1, SYNC_POL);
      vsync_q       <= sync_level(vs_p1, SYNC_POL);
      pix_c_q       <= pix_c_d;
      frame_start_q <= fs_p1;
      underrun_q    <= underrun_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_c       = pix_c_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  // ---- flip: decided at (0, V_ACTIVE), strobe registered the next cycle ----
  // A request in the decision cycle is consumed by that flip; any later one
  // re-arms for the following frame. Multiple requests collapse.
  logic flip_pending_q, flip_pending_d;
  logic flip_q, flip_d;

  always_comb begin
    flip_d         = blank_start & (flip_pending_q | flip_req);
    flip_pending_d = flip_pending_q | flip_req;
    if (flip_d) flip_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flip_pending_q <= 1'b0;
      flip_q         <= 1'b0;
    end else begin
      flip_pending_q <= flip_pending_d;
      flip_q         <= flip_d;
    end
  end

  assign display_flip = flip_q;
  assign flip_done    = flip_q;

endmodule

// File: tb/tb_display_scanout.sv
module tb_display_scanout;

  // Small raster so whole frames stay short: 24 x 19, 16 x 12 visible.
  localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BUDGET = 2 * FT + 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flip_req = 1'b0;
  logic       rd_vld = 1'b1;
  logic       underrun_clr = 1'b0;
  logic [3:0] rd_c;
  logic       display_flip, flip_done, rd_en, hsync, vsync, de, frame_start, underrun;
  logic [8:0] rd_x, rd_y;
  logic [3:0] pix_c;

  int n_checks = 0;
  int n_errors = 0;

  display_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .flip_req(flip_req),
    .display_flip(display_flip), .flip_done(flip_done),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_c(rd_c), .rd_vld(rd_vld),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_c(pix_c),
    .frame_start(frame_start), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  // Frame store: colour = low 4 bits of the column, one cycle latency.
  always @(posedge clk) rd_c <= rd_x[3:0];

  // Reference raster position and its two-cycle-old copies.
  int ex_h = 0, ex_v = 0, h1 = 0, v1 = 0, h2 = 0, v2 = 0;
  bit ok1 = 0, ok2 = 0;

  always @(posedge clk) begin
    if (rst) begin
      ex_h <= 0; ex_v <= 0; ok1 <= 0;
    end else begin
      ex_h <= (ex_h == HT - 1) ? 0 : ex_h + 1;
      if (ex_h == HT - 1) ex_v <= (ex_v == VT - 1) ? 0 : ex_v + 1;
      h1 <= ex_h; v1 <= ex_v; ok1 <= 1;
    end
    h2 <= h1; v2 <= v1; ok2 <= rst ? 1'b0 : ok1;
  end

  function automatic bit in_act(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  bit stream_en = 0, count_en = 0;
  int err_de = 0, err_hs = 0, err_vs = 0, err_pix = 0, err_fs = 0, err_rd = 0, err_fd = 0;
  int cnt_hs = 0, cnt_vs = 0, cnt_de = 0, cnt_fs = 0;
  int flip_cnt = 0, flip_h = -1, flip_v = -1;

  always @(negedge clk) begin
    bit e_de, e_rd;
    e_de = ok2 && in_act(h2, v2);
    e_rd = !rst && in_act(ex_h, ex_v);
    if (stream_en) begin
      if (de !== e_de) err_de++;
      if (hsync !== !(ok2 && h2 >= HA + HF && h2 < HA + HF + HS)) err_hs++;
      if (vsync !== !(ok2 && v2 >= VA + VF && v2 < VA + VF + VS)) err_vs++;
      if (pix_c !== (e_de ? 4'(h2 >> 1) : 4'd0)) err_pix++;
      if (frame_start !== (ok2 && h2 == 0 && v2 == 0)) err_fs++;
      if (rd_en !== e_rd || rd_x !== (e_rd ? 9'(ex_h >> 1) : 9'd0) ||
          rd_y !== (e_rd ? 9'(ex_v >> 1) : 9'd0)) err_rd++;
    end
    if (display_flip !== flip_done) err_fd++;
    if (display_flip === 1'b1) begin
      flip_cnt++; flip_h = ex_h; flip_v = ex_v;
    end
    if (count_en) begin
      if (hsync === 1'b0) cnt_hs++;
      if (vsync === 1'b0) cnt_vs++;
      if (de === 1'b1) cnt_de++;
      if (frame_start === 1'b1) cnt_fs++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(ex_h == h && ex_v == v) && n < BUDGET);
    check($sformatf("reach_%0d_%0d", h, v), n < BUDGET, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_xy"}, {rd_x, rd_y}, 0);
    check({tag, "_de"}, de, 0);
    check({tag, "_pix"}, pix_c, 0);
    check({tag, "_syncs"}, {hsync, vsync}, 2'b11);
    check({tag, "_flip"}, {display_flip, flip_done}, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  int base;

  initial begin
    repeat (4) tick();
    check_reset_outputs("por");
    rst = 1'b0;
    #1;
    check("first_rd_en", rd_en, 1);
    check("first_rd_xy", {rd_x, rd_y}, 0);
    stream_en = 1;
    count_en = 1;
    repeat (2 * FT) tick();
    count_en = 0;
    check("hsync_low_cycles", cnt_hs, HS * VT * 2);
    check("vsync_low_cycles", cnt_vs, VS * HT * 2);
    check("de_cycles", cnt_de, HA * VA * 2);
    check("frame_starts", cnt_fs, 2);

    // Pixel doubling: at (12,3) the pins show column 10 -> buffer x 5.
    wait_pos(12, 3);
    check("dbl_pix_even", pix_c, 5);
    tick();
    check("dbl_pix_odd", pix_c, 5);
    tick();
    check("dbl_pix_next", pix_c, 6);

    // Underrun on the data cycle of request (6,5).
    stream_en = 0;
    check("underrun_idle", underrun, 0);
    wait_pos(6, 5);
    tick(); rd_vld = 1'b0;
    tick(); rd_vld = 1'b1;
    check("ur_pix_zero", pix_c, 0);
    check("ur_de", de, 1);
    check("ur_flag", underrun, 1);
    tick();
    check("ur_next_pix", pix_c, 3);
    repeat (30) tick();
    check("ur_hold", underrun, 1);
    underrun_clr = 1'b1;
    tick(); underrun_clr = 1'b0;
    check("ur_cleared", underrun, 0);
    wait_pos(6, 7);
    tick(); rd_vld = 1'b0;
    tick(); underrun_clr = 1'b1;
    tick(); rd_vld = 1'b1; underrun_clr = 1'b0;
    check("ur_set_beats_clr", underrun, 1);
    repeat (3) tick();
    stream_en = 1;

    // Single request mid-frame -> one flip, strobe at (1,VA).
    base = flip_cnt;
    wait_pos(0, 4);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    wait_pos(5, VA);
    check("flip1_count", flip_cnt - base, 1);
    check("flip1_pos", {16'(flip_h), 16'(flip_v)}, {16'd1, 16'(VA)});
    wait_pos(5, VA);
    check("flip1_no_repeat", flip_cnt - base, 1);

    // Two requests in one frame collapse.
    base = flip_cnt;
    wait_pos(0, 1);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    wait_pos(3, 8);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    wait_pos(5, VA);
    check("flip2_collapse", flip_cnt - base, 1);

    // Request exactly at (0,VA) flips now; one at (1,VA) waits a frame.
    base = flip_cnt;
    wait_pos(0, VA);
    flip_req = 1'b1;
    tick();
    check("flip3_same_cycle", display_flip, 1);
    tick(); flip_req = 1'b0;
    check("flip3_one_cycle", display_flip, 0);
    wait_pos(5, VA);
    check("flip4_not_this_frame", flip_cnt - base, 1);
    wait_pos(5, VA);
    check("flip4_next_frame", flip_cnt - base, 2);

    // Mid-frame reset with a flip pending.
    base = flip_cnt;
    wait_pos(0, 3);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    wait_pos(10, 7);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs($sformatf("rst%0d", i));
    end
    rst = 1'b0;
    #1;
    check("post_rst_rd_en", rd_en, 1);
    check("post_rst_rd_xy", {rd_x, rd_y}, 0);
    wait_pos(5, VA);
    check("rst_drops_pending", flip_cnt - base, 0);
    wait_pos(0, 3);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    wait_pos(5, VA);
    check("reissued_flip", flip_cnt - base, 1);

    check("stream_de", err_de, 0);
    check("stream_hsync", err_hs, 0);
    check("stream_vsync", err_vs, 0);
    check("stream_pix", err_pix, 0);
    check("stream_frame_start", err_fs, 0);
    check("stream_rd_req", err_rd, 0);
    check("flip_done_match", err_fd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
